config_logic_block: RTL and testbench

//  Parametrised successor to the fixed 5-input logic tile. Holds N K-input LUTs, each with an optional output register.

---
 rtl/clb_pkg.sv | 23 ++
 rtl/clb_lut.sv | 14 +
 rtl/config_logic_block.sv | 160 ++++++++++++++++
 tb/tb_config_logic_block.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared types and sizing helpers for the configurable logic block.
package clb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } clb_state_e;

  // Config bits per LUT: truth table plus one mode bit.
  function automatic int clb_w(input int k);
    return (2 ** k) + 1;
  endfunction

  function automatic int clb_total(input int k, input int n);
    return n * clb_w(k);
  endfunction

  function automatic int clb_cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/clb_lut.sv
// K-input look-up table: selects one truth-table bit by address.
module clb_lut
  import clb_pkg::*;
#(
  parameter int K = 4
) (
  input  logic [(2**K)-1:0] lut_table,
  input  logic [K-1:0]      addr,
  output logic              f
);

  assign f = lut_table[addr];

endmodule

// File: rtl/config_logic_block.sv
// N K-input LUTs with optional output registers, serially configured by a load FSM.
// Optional build macro CLB_READBACK_EN adds serial readback of displaced config bits on cfg_dout.
module config_logic_block
  import clb_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 2
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_din,
  output logic           cfg_ready,
  output logic           cfg_done,
  output logic           cfg_dout,
  input  logic [N*K-1:0] in,
  output logic [N-1:0]   out
);

  localparam int W     = clb_w(K);
  localparam int TOTAL = clb_total(K, N);
  localparam int CW    = clb_cnt_w(TOTAL);
  localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);

  clb_state_e      state_r;
  logic [CW-1:0]   cnt_r;
  logic [TOTAL-1:0] cfg_r;
  logic [N-1:0]    ff_r;
  logic            cfg_ready_r;
  logic            cfg_done_r;
  logic            shift_en_s;
  logic [N-1:0]    lut_f_s;
  logic [N-1:0]    mode_s;
  logic [N-1:0]    out_s;

  // cfg_start outranks a same-cycle config bit
  assign shift_en_s = (state_r == LOAD) && cfg_valid && !cfg_start;

  for (genvar i = 0; i < N; i++) begin : g_lut
    clb_lut #(.K(K)) u_lut (
      .lut_table (cfg_r[i*W +: (2**K)]),
      .addr      (in[i*K +: K]),
      .f         (lut_f_s[i])
    );
    assign mode_s[i] = cfg_r[i*W + (2**K)];
  end

  // Load FSM: state, bit counter and registered handshake flags
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      cfg_ready_r <= 1'b0;
      cfg_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_start) begin
            state_r     <= LOAD;
            cnt_r       <= '0;
            cfg_ready_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            cnt_r <= '0;
          end else if (cfg_valid) begin
            if (cnt_r == CNT_LAST) begin
              state_r     <= ACTIVE;
              cnt_r       <= '0;
              cfg_ready_r <= 1'b0;
              cfg_done_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ACTIVE: begin
          if (cfg_start) begin
            state_r     <= LOAD;
            cnt_r       <= '0;
            cfg_ready_r <= 1'b1;
            cfg_done_r  <= 1'b0;
          end else begin
            state_r <= ACTIVE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          cfg_ready_r <= 1'b0;
          cfg_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Config shift register: first bit sent ends in cfg_r[0]
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r <= '0;
    end else if (shift_en_s) begin
      cfg_r <= {cfg_din, cfg_r[TOTAL-1:1]};
    end else begin
      cfg_r <= cfg_r;
    end
  end

  // User flops track the LUTs only while live; any reload clears them
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ff_r <= '0;
    end else if ((state_r == ACTIVE) && !cfg_start) begin
      ff_r <= lut_f_s;
    end else begin
      ff_r <= '0;
    end
  end

  // Output mux: combinational or registered per LUT, forced low unless ACTIVE
  always_comb begin
    out_s = '0;
    if (state_r == ACTIVE) begin
      for (int i = 0; i < N; i++) begin
        out_s[i] = mode_s[i] ? ff_r[i] : lut_f_s[i];
      end
    end else begin
      out_s = '0;
    end
  end

`ifdef CLB_READBACK_EN
  logic cfg_dout_r;

  // Capture the bit displaced by each accepted shift
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cfg_dout_r <= 1'b0;
    end else if (shift_en_s) begin
      cfg_dout_r <= cfg_r[0];
    end else begin
      cfg_dout_r <= cfg_dout_r;
    end
  end

  assign cfg_dout = cfg_dout_r;
`else
  assign cfg_dout = 1'b0;
`endif

  assign cfg_ready = cfg_ready_r;
  assign cfg_done  = cfg_done_r;
  assign out       = out_s;

endmodule

// File: tb/tb_config_logic_block.sv
// Directed bench for config_logic_block (K=4, N=2): AND4 combinational + XOR4 registered.
module tb_config_logic_block;

  logic       clock;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_din;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_dout;
  logic [7:0] in;
  logic [1:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  // LUT0 = AND4 (mode 0), LUT1 = XOR4 (mode 1); bit 0 is sent first
  logic [33:0] stream;
  logic [33:0] zeros;

  config_logic_block #(.K(4), .N(2)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_din   (cfg_din),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_dout  (cfg_dout),
    .in        (in),
    .out       (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Sends bits[0..nbits-1]; gap inserts an idle cycle before every bit but the first.
  // Done is checked low after bit 33 of 34 and high right after the last bit.
  task automatic send_bits(input logic [33:0] bits, input int nbits, input bit gap,
                           input bit chk_dout, input logic [33:0] prev);
    for (int j = 0; j < nbits; j++) begin
      if (gap && j > 0) begin
        cfg_valid = 1'b0;
        cfg_din   = ~bits[j];
        tick();
        check_val("gap_ready", 64'(cfg_ready), 64'(1'b1));
        check_val("gap_done", 64'(cfg_done), 64'(1'b0));
      end
      cfg_valid = 1'b1;
      cfg_din   = bits[j];
      tick();
      cfg_valid = 1'b0;
      if (chk_dout) begin
`ifdef CLB_READBACK_EN
        check_val($sformatf("dout_%0d", j), 64'(cfg_dout), 64'(prev[j]));
`else
        check_val($sformatf("dout_%0d", j), 64'(cfg_dout), 64'(1'b0));
`endif
      end
      if (j == 17) check_val("load_out_zero", 64'(out), 64'(2'b00));
      if (nbits == 34 && j == 32) check_val("done_early", 64'(cfg_done), 64'(1'b0));
      if (nbits == 34 && j == 33) check_val("done_after_34", 64'(cfg_done), 64'(1'b1));
    end
  endtask

  // First ACTIVE cycle with in=1F: AND4 live immediately, XOR4 one cycle later
  task automatic check_function(input string tag);
    in = 8'h1F;
    #1;
    check_val({tag, "_out_comb"}, 64'(out), 64'(2'b01));
    tick();
    check_val({tag, "_out_reg"}, 64'(out), 64'(2'b11));
  endtask

  initial begin
    stream    = {1'b1, 16'h6996, 1'b0, 16'h8000};
    zeros     = 34'd0;
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_din   = 1'b0;
    in        = 8'h1F;
    tick();
    check_val("rst_out", 64'(out), 64'(2'b00));
    check_val("rst_ready", 64'(cfg_ready), 64'(1'b0));
    check_val("rst_done", 64'(cfg_done), 64'(1'b0));
    check_val("rst_dout", 64'(cfg_dout), 64'(1'b0));
    #2 rst_n = 1'b1;
    tick();
    check_val("idle_out", 64'(out), 64'(2'b00));
    check_val("idle_ready", 64'(cfg_ready), 64'(1'b0));

    // Test 1: back-to-back load, then function checks
    in = 8'h00;
    pulse_start();
    check_val("t1_ready", 64'(cfg_ready), 64'(1'b1));
    in = 8'h1F;
    send_bits(stream, 34, 1'b0, 1'b1, zeros);
    check_val("t1_ready_low", 64'(cfg_ready), 64'(1'b0));
    check_val("t1_out_comb", 64'(out), 64'(2'b01));
    tick();
    check_val("t1_out_reg", 64'(out), 64'(2'b11));
    in = 8'h0F;
    #1;
    check_val("t1_in0F_comb", 64'(out), 64'(2'b11));
    tick();
    check_val("t1_in0F_reg", 64'(out), 64'(2'b01));
    in = 8'h3E;
    #1;
    check_val("t1_in3E_comb", 64'(out), 64'(2'b00));
    in = 8'h2F;
    #1;
    check_val("t1_in2F_comb", 64'(out), 64'(2'b01));
    tick();
    check_val("t1_in2F_reg", 64'(out), 64'(2'b11));
    tick();
    check_val("t1_done_hold", 64'(cfg_done), 64'(1'b1));

    // Test 4: reload from ACTIVE with out[1]=1
    in = 8'h1F;
    tick();
    check_val("t4_pre_out", 64'(out), 64'(2'b11));
    pulse_start();
    check_val("t4_ready", 64'(cfg_ready), 64'(1'b1));
    check_val("t4_done", 64'(cfg_done), 64'(1'b0));
    check_val("t4_out", 64'(out), 64'(2'b00));

    // Test 2: same stream with idle cycles between bits (last valid bit on cycle 67)
    send_bits(stream, 34, 1'b1, 1'b0, zeros);
    check_function("t2");

    // Test 3: async reset in mid-load, then a full reload is needed
    pulse_start();
    send_bits(stream, 20, 1'b0, 1'b0, zeros);
    #2 rst_n = 1'b0;
    #1;
    check_val("t3_rst_out", 64'(out), 64'(2'b00));
    check_val("t3_rst_ready", 64'(cfg_ready), 64'(1'b0));
    check_val("t3_rst_done", 64'(cfg_done), 64'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_bits(stream, 34, 1'b0, 1'b0, zeros);
    check_function("t3");

    // Test 5: restart after 10 bits; cfg_start outranks a valid bit in the same cycle
    pulse_start();
    send_bits(stream, 10, 1'b0, 1'b0, zeros);
    cfg_valid = 1'b1;
    cfg_din   = 1'b1;
    pulse_start();
    cfg_valid = 1'b0;
    check_val("t5_ready", 64'(cfg_ready), 64'(1'b1));
    send_bits(stream, 34, 1'b0, 1'b0, zeros);
    check_function("t5");

    // Test 6: load zeros; readback returns the previous stream, then all outputs stay low
    pulse_start();
    send_bits(zeros, 34, 1'b0, 1'b1, stream);
    in = 8'h1F;
    #1;
    check_val("t6_out_1F", 64'(out), 64'(2'b00));
    tick();
    check_val("t6_out_1F_reg", 64'(out), 64'(2'b00));
    in = 8'hFF;
    tick();
    check_val("t6_out_FF", 64'(out), 64'(2'b00));
    in = 8'h10;
    tick();
    check_val("t6_out_10", 64'(out), 64'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
